// File: rtl/pipeline_ctrl.sv
// Hazard, forwarding and debug-halt sequencing controller for a 5-stage RV32I pipeline.
// Stage controls and forwarding selects are combinational; debug state and counters are registered.
module pipeline_ctrl (
  input  logic        clk,
  input  logic        rstn,
  input  logic [4:0]  id_rf_raddr_rs1,
  input  logic [4:0]  id_rf_raddr_rs2,
  input  logic [4:0]  ex_rf_raddr_rs1,
  input  logic [4:0]  ex_rf_raddr_rs2,
  input  logic [4:0]  ex_rf_waddr,
  input  logic        ex_rf_we,
  input  logic [6:0]  ex_opcode,
  input  logic        ex_bu_branch,
  input  logic [4:0]  mem_rf_waddr,
  input  logic        mem_rf_we,
  input  logic [4:0]  wb_rf_waddr,
  input  logic        wb_rf_we,
  input  logic        im_ready,
  input  logic        mem_dm_req,
  input  logic        dm_ready,
  input  logic        dbg_halt_req,
  input  logic        dbg_step,
  output logic        pc_enable,
  output logic        if_id_enable,
  output logic        id_ex_enable,
  output logic        ex_mem_enable,
  output logic        mem_wb_enable,
  output logic        if_id_rstn,
  output logic        id_ex_rstn,
  output logic        ex_mem_rstn,
  output logic        mem_wb_rstn,
  output logic [1:0]  ex_rf_dout_rs1_sel,
  output logic [1:0]  ex_rf_dout_rs2_sel,
  output logic        halted,
  output logic [31:0] perf_stall_cnt
);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED, STEP} state_t;

  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_WB  = 2'b10;

  state_t     state;
  logic [1:0] dcnt;
  logic       lu_stall;
  logic       dm_wait;
  logic       fetch_gate;
  logic       advance;
  logic       stall_cycle;

  // Conservative: both ID source fields are compared even if the consumer uses only one.
  assign lu_stall = (ex_opcode == OP_LOAD) && ex_rf_we && (ex_rf_waddr != 5'd0) &&
                    ((ex_rf_waddr == id_rf_raddr_rs1) || (ex_rf_waddr == id_rf_raddr_rs2));
  assign dm_wait     = mem_dm_req && !dm_ready;
  assign fetch_gate  = !im_ready || (state == DRAIN) || (state == HALTED);
  assign advance     = !dm_wait && !lu_stall;
  assign stall_cycle = dm_wait || lu_stall || !im_ready;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic       m_we, input logic [4:0] m_wa,
                                         input logic       w_we, input logic [4:0] w_wa);
    if (rs == 5'd0)                 return SEL_RF;
    else if (m_we && (m_wa == rs))  return SEL_MEM;
    else if (w_we && (w_wa == rs))  return SEL_WB;
    else                            return SEL_RF;
  endfunction

  // NOTE: every output gets a default before the priority chain so no path leaves one unassigned (no latch).
  always_comb begin
    pc_enable          = 1'b1;
    if_id_enable       = 1'b1;
    id_ex_enable       = 1'b1;
    ex_mem_enable      = 1'b1;
    mem_wb_enable      = 1'b1;
    if_id_rstn         = 1'b1;
    id_ex_rstn         = 1'b1;
    ex_mem_rstn        = 1'b1;
    mem_wb_rstn        = 1'b1;
    ex_rf_dout_rs1_sel = fwd_sel(ex_rf_raddr_rs1, mem_rf_we, mem_rf_waddr, wb_rf_we, wb_rf_waddr);
    ex_rf_dout_rs2_sel = fwd_sel(ex_rf_raddr_rs2, mem_rf_we, mem_rf_waddr, wb_rf_we, wb_rf_waddr);
    if (!rstn) begin
      {pc_enable, if_id_enable, id_ex_enable, ex_mem_enable, mem_wb_enable} = '0;
      {if_id_rstn, id_ex_rstn, ex_mem_rstn, mem_wb_rstn}                   = '0;
      ex_rf_dout_rs1_sel = SEL_RF;
      ex_rf_dout_rs2_sel = SEL_RF;
    end else if (dm_wait) begin
      // EX is frozen, so a pending branch simply re-presents once memory answers.
      pc_enable     = 1'b0;
      if_id_enable  = 1'b0;
      id_ex_enable  = 1'b0;
      ex_mem_enable = 1'b0;
      mem_wb_rstn   = 1'b0;
    end else if (ex_bu_branch) begin
      if_id_rstn = 1'b0;
      id_ex_rstn = 1'b0;
    end else if (lu_stall) begin
      pc_enable    = 1'b0;
      if_id_enable = 1'b0;
      id_ex_rstn   = 1'b0;
    end else if (fetch_gate) begin
      pc_enable  = 1'b0;
      if_id_rstn = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= RUN;
      dcnt           <= 2'd0;
      halted         <= 1'b0;
      perf_stall_cnt <= 32'd0;
    end else begin
      if (stall_cycle) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      case (state)
        RUN: if (dbg_halt_req) begin
          state <= DRAIN;
          dcnt  <= 2'd0;
        end
        DRAIN: begin
          if (!dbg_halt_req) begin
            state <= RUN;
          end else if (advance) begin
            if (dcnt == 2'd3) begin
              state  <= HALTED;
              halted <= 1'b1;
            end else begin
              dcnt <= dcnt + 2'd1;
            end
          end
        end
        HALTED: begin
          if (dbg_step) begin
            state  <= STEP;
            halted <= 1'b0;
          end else if (!dbg_halt_req) begin
            state  <= RUN;
            halted <= 1'b0;
          end
        end
        STEP: if (im_ready) begin
          state <= DRAIN;
          dcnt  <= 2'd0;
        end
        default: begin
          state  <= RUN;
          halted <= 1'b0;
        end
      endcase
    end
  end

endmodule
